// File: rtl/stream_decoder_pipe.sv
// Stream-to-binary decoder: accumulates NCH signed channels over 2^k beats and emits normalised words.
// Optional macro DECODER_ROUND_EN selects round-half-up with positive saturation instead of floor truncation.
module stream_decoder_pipe #(
  parameter int NCH    = 4,
  parameter int WSTR   = 2,
  parameter int WR_MAX = 8,
  parameter int WOUT   = WSTR + WR_MAX - 1
) (
  input  logic                             iCLK,
  input  logic                             iRST,
  input  logic [$clog2(WR_MAX+1)-1:0]      iWinLog,
  input  logic                             iValid_AS,
  output logic                             oReady_AS,
  input  logic [NCH*WSTR-1:0]              iData_AS,
  output logic                             oValid_BS,
  input  logic                             iReady_BS,
  output logic [NCH*WOUT-1:0]              oData_BS
);

  localparam int WACC = WSTR + WR_MAX;
  localparam int WL_W = $clog2(WR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_HOLD = 2'd2} state_t;

  state_t                  state;
  logic                    rdy;
  logic [WR_MAX-1:0]       cnt_p0;
  logic [WL_W-1:0]         kw_p0;
  logic signed [WACC-1:0]  acc_p0  [NCH];
  logic signed [WACC-1:0]  acc_sum [NCH];
  logic [WL_W-1:0]         k_in;
  logic [WL_W-1:0]         k_cur;
  logic [WR_MAX:0]         win_len;
  logic                    last;
  logic                    accept;
  logic [NCH*WOUT-1:0]     res;
  logic                    vld_p1;
  logic [NCH*WOUT-1:0]     data_p1;

  function automatic logic [WL_W-1:0] clamp_k(input logic [WL_W-1:0] k);
    if (int'(k) > WR_MAX) return WL_W'(WR_MAX);
    return k;
  endfunction

`ifdef DECODER_ROUND_EN
  localparam int RND_SH = (WACC > WOUT) ? (WACC - WOUT - 1) : 0;
  localparam logic [WACC:0] RND_HALF = (WACC + 1)'((WACC > WOUT) ? 1 : 0) << RND_SH;

  // Only positive overflow is possible since the rounding constant is non-negative.
  function automatic logic signed [WOUT-1:0] round_sat(input logic signed [WACC-1:0] n);
    logic signed [WACC:0]   ext;
    logic signed [WOUT-1:0] maxp;
    ext  = {n[WACC-1], n} + RND_HALF;
    maxp = '1;
    maxp[WOUT-1] = 1'b0;
    if (ext[WACC] != ext[WACC-1]) return maxp;
    return ext[WACC-1 -: WOUT];
  endfunction
`endif

  function automatic logic signed [WOUT-1:0] normalise(input logic signed [WACC-1:0] a,
                                                       input logic [WL_W-1:0] k);
    logic signed [WACC-1:0] n;
    n = a <<< (WR_MAX - int'(k));
`ifdef DECODER_ROUND_EN
    return round_sat(n);
`else
    return n[WACC-1 -: WOUT];
`endif
  endfunction

  always_comb begin
    k_in    = clamp_k(iWinLog);
    // The exponent is sampled on the first beat of a window and frozen afterwards.
    k_cur   = (cnt_p0 == '0) ? k_in : kw_p0;
    win_len = (WR_MAX + 1)'(1) << k_cur;
    last    = ({1'b0, cnt_p0} == (win_len - (WR_MAX + 1)'(1)));
    accept  = iValid_AS && rdy;
    res     = '0;
    for (int c = 0; c < NCH; c++) begin
      acc_sum[c] = acc_p0[c] + {{WR_MAX{iData_AS[c*WSTR+WSTR-1]}}, iData_AS[c*WSTR +: WSTR]};
      res[c*WOUT +: WOUT] = (state == S_HOLD) ? normalise(acc_p0[c], kw_p0)
                                              : normalise(acc_sum[c], k_cur);
    end
  end

  // Stage p0: accumulation and control; stage p1: registered output word.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= S_IDLE;
      rdy     <= 1'b0;
      cnt_p0  <= '0;
      kw_p0   <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      for (int c = 0; c < NCH; c++) acc_p0[c] <= '0;
    end else begin
      if (vld_p1 && iReady_BS) vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= S_ACC;
          rdy   <= 1'b1;
        end
        S_ACC: begin
          if (accept) begin
            if (!last) begin
              cnt_p0 <= cnt_p0 + 1'b1;
              kw_p0  <= k_cur;
              for (int c = 0; c < NCH; c++) acc_p0[c] <= acc_sum[c];
            end else if (!vld_p1 || iReady_BS) begin
              data_p1 <= res;
              vld_p1  <= 1'b1;
              cnt_p0  <= '0;
              for (int c = 0; c < NCH; c++) acc_p0[c] <= '0;
            end else begin
              kw_p0 <= k_cur;
              state <= S_HOLD;
              rdy   <= 1'b0;
              for (int c = 0; c < NCH; c++) acc_p0[c] <= acc_sum[c];
            end
          end
        end
        S_HOLD: begin
          if (vld_p1 && iReady_BS) begin
            data_p1 <= res;
            vld_p1  <= 1'b1;
            cnt_p0  <= '0;
            state   <= S_ACC;
            rdy     <= 1'b1;
            for (int c = 0; c < NCH; c++) acc_p0[c] <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign oReady_AS = rdy;
  assign oValid_BS = vld_p1;
  assign oData_BS  = data_p1;

endmodule

// File: tb/tb_stream_decoder_pipe.sv
// Directed bench for stream_decoder_pipe with NCH=2, WSTR=2, WR_MAX=4, WOUT=5.
module tb_stream_decoder_pipe;

  logic        iCLK;
  logic        iRST;
  logic [2:0]  iWinLog;
  logic        iValid_AS;
  logic        oReady_AS;
  logic [3:0]  iData_AS;
  logic        oValid_BS;
  logic        iReady_BS;
  logic [9:0]  oData_BS;
  logic signed [4:0] o0, o1;

  int n_vec = 0;
  int n_err = 0;

  stream_decoder_pipe #(.NCH(2), .WSTR(2), .WR_MAX(4), .WOUT(5)) dut (
    .iCLK(iCLK), .iRST(iRST), .iWinLog(iWinLog),
    .iValid_AS(iValid_AS), .oReady_AS(oReady_AS), .iData_AS(iData_AS),
    .oValid_BS(oValid_BS), .iReady_BS(iReady_BS), .oData_BS(oData_BS)
  );

  assign o0 = oData_BS[4:0];
  assign o1 = oData_BS[9:5];

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic drive(input logic v, input logic signed [1:0] d0, input logic signed [1:0] d1);
    iValid_AS = v;
    iData_AS  = {d1, d0};
  endtask

  task automatic test_reset();
    iRST = 1'b1; iReady_BS = 1'b0; iWinLog = 3'd4; drive(1'b0, 2'sd0, 2'sd0);
    repeat (2) @(negedge iCLK);
    n_vec++; if (oValid_BS !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", oValid_BS); end
    n_vec++; if (oData_BS !== 10'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", oData_BS); end
    n_vec++; if (oReady_AS !== 1'b0) begin n_err++; $display("FAIL reset_rdy: got %b want 0", oReady_AS); end
    iRST = 1'b0;
    @(negedge iCLK);
    n_vec++; if (oReady_AS !== 1'b1) begin n_err++; $display("FAIL reset_first_rdy: got %b want 1", oReady_AS); end
  endtask

  task automatic test_full_window();
    iReady_BS = 1'b1; iWinLog = 3'd4;
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (oValid_BS !== 1'b0) begin n_err++; $display("FAIL full_early_vld beat %0d: got %b want 0", i, oValid_BS); end
      drive(1'b1, 2'sd1, -2'sd1);
      @(negedge iCLK);
    end
    drive(1'b0, 2'sd0, 2'sd0);
    n_vec++; if (oValid_BS !== 1'b1) begin n_err++; $display("FAIL full_vld: got %b want 1", oValid_BS); end
    n_vec++; if (o0 !== 5'sd8) begin n_err++; $display("FAIL full_ch0: got %0d want 8", o0); end
    n_vec++; if (o1 !== -5'sd8) begin n_err++; $display("FAIL full_ch1: got %0d want -8", o1); end
    @(negedge iCLK);
    n_vec++; if (oValid_BS !== 1'b0) begin n_err++; $display("FAIL full_vld_drop: got %b want 0", oValid_BS); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    iReady_BS = 1'b1; iWinLog = 3'd2;
    for (int j = 0; j <= 16; j++) begin
      exp_v = (j > 0) && (j % 4 == 0);
      n_vec++; if (oValid_BS !== exp_v) begin n_err++; $display("FAIL b2b_vld cycle %0d: got %b want %b", j, oValid_BS, exp_v); end
      if (exp_v) begin
        n_vec++; if (o0 !== 5'sd8) begin n_err++; $display("FAIL b2b_ch0 cycle %0d: got %0d want 8", j, o0); end
        n_vec++; if (o1 !== 5'sd0) begin n_err++; $display("FAIL b2b_ch1 cycle %0d: got %0d want 0", j, o1); end
      end
      if (j < 16) drive(1'b1, 2'sd1, 2'sd0); else drive(1'b0, 2'sd0, 2'sd0);
      @(negedge iCLK);
    end
  endtask

  task automatic test_backpressure();
    iReady_BS = 1'b0; iWinLog = 3'd1;
    for (int j = 0; j < 4; j++) begin
      n_vec++; if (oReady_AS !== 1'b1) begin n_err++; $display("FAIL bp_rdy beat %0d: got %b want 1", j, oReady_AS); end
      if (j >= 2) begin
        n_vec++; if (oValid_BS !== 1'b1 || o0 !== 5'sd8 || o1 !== 5'sd8) begin
          n_err++; $display("FAIL bp_first beat %0d: got vld=%b ch0=%0d ch1=%0d want 1/8/8", j, oValid_BS, o0, o1);
        end
      end
      drive(1'b1, 2'sd1, (j < 2) ? 2'sd1 : -2'sd1);
      @(negedge iCLK);
    end
    drive(1'b0, 2'sd0, 2'sd0);
    for (int s = 0; s < 2; s++) begin
      n_vec++; if (oReady_AS !== 1'b0) begin n_err++; $display("FAIL bp_stall_rdy %0d: got %b want 0", s, oReady_AS); end
      n_vec++; if (oValid_BS !== 1'b1 || o0 !== 5'sd8 || o1 !== 5'sd8) begin
        n_err++; $display("FAIL bp_stall_data %0d: got vld=%b ch0=%0d ch1=%0d want 1/8/8", s, oValid_BS, o0, o1);
      end
      @(negedge iCLK);
    end
    iReady_BS = 1'b1;
    @(negedge iCLK);
    n_vec++; if (oValid_BS !== 1'b1 || o0 !== 5'sd8 || o1 !== -5'sd8) begin
      n_err++; $display("FAIL bp_second: got vld=%b ch0=%0d ch1=%0d want 1/8/-8", oValid_BS, o0, o1);
    end
    n_vec++; if (oReady_AS !== 1'b1) begin n_err++; $display("FAIL bp_rdy_return: got %b want 1", oReady_AS); end
    @(negedge iCLK);
    n_vec++; if (oValid_BS !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", oValid_BS); end
  endtask

  task automatic test_rounding();
    logic signed [4:0] exp0, exp1;
`ifdef DECODER_ROUND_EN
    exp0 = 5'sd8;  exp1 = -5'sd7;
`else
    exp0 = 5'sd7;  exp1 = -5'sd8;
`endif
    iReady_BS = 1'b1; iWinLog = 3'd4;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) drive(1'b1, 2'sd1, -2'sd1); else drive(1'b1, 2'sd0, 2'sd0);
      @(negedge iCLK);
    end
    drive(1'b0, 2'sd0, 2'sd0);
    n_vec++; if (oValid_BS !== 1'b1) begin n_err++; $display("FAIL round_vld: got %b want 1", oValid_BS); end
    n_vec++; if (o0 !== exp0) begin n_err++; $display("FAIL round_ch0: got %0d want %0d", o0, exp0); end
    n_vec++; if (o1 !== exp1) begin n_err++; $display("FAIL round_ch1: got %0d want %0d", o1, exp1); end
    @(negedge iCLK);
  endtask

  task automatic test_async_reset();
    iReady_BS = 1'b0; iWinLog = 3'd0;
    drive(1'b1, 2'sd1, 2'sd0);
    @(negedge iCLK);
    drive(1'b0, 2'sd0, 2'sd0);
    n_vec++; if (oValid_BS !== 1'b1 || o0 !== 5'sd8) begin
      n_err++; $display("FAIL ar_pending: got vld=%b ch0=%0d want 1/8", oValid_BS, o0);
    end
    iWinLog = 3'd4;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 2'sd1, 2'sd1);
      @(negedge iCLK);
    end
    drive(1'b0, 2'sd0, 2'sd0);
    #2 iRST = 1'b1;
    #1;
    n_vec++; if (oValid_BS !== 1'b0) begin n_err++; $display("FAIL ar_vld: got %b want 0", oValid_BS); end
    n_vec++; if (oData_BS !== 10'd0) begin n_err++; $display("FAIL ar_data: got %h want 0", oData_BS); end
    n_vec++; if (oReady_AS !== 1'b0) begin n_err++; $display("FAIL ar_rdy: got %b want 0", oReady_AS); end
    #1 iRST = 1'b0;
    iReady_BS = 1'b1;
    @(negedge iCLK);
    n_vec++; if (oReady_AS !== 1'b1) begin n_err++; $display("FAIL ar_rdy_after: got %b want 1", oReady_AS); end
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (oValid_BS !== 1'b0) begin n_err++; $display("FAIL ar_early_vld beat %0d: got %b want 0", i, oValid_BS); end
      drive(1'b1, 2'sd1, 2'sd1);
      @(negedge iCLK);
    end
    drive(1'b0, 2'sd0, 2'sd0);
    n_vec++; if (oValid_BS !== 1'b1 || o0 !== 5'sd8 || o1 !== 5'sd8) begin
      n_err++; $display("FAIL ar_result: got vld=%b ch0=%0d ch1=%0d want 1/8/8", oValid_BS, o0, o1);
    end
    @(negedge iCLK);
  endtask

  task automatic test_win_change();
    logic exp_v;
    iReady_BS = 1'b1;
    for (int j = 0; j <= 20; j++) begin
      iWinLog = (j >= 4) ? 3'd2 : 3'd4;
      exp_v = (j == 16) || (j == 20);
      n_vec++; if (oValid_BS !== exp_v) begin n_err++; $display("FAIL wc_vld cycle %0d: got %b want %b", j, oValid_BS, exp_v); end
      if (exp_v) begin
        n_vec++; if (o0 !== 5'sd8 || o1 !== -5'sd8) begin
          n_err++; $display("FAIL wc_data cycle %0d: got ch0=%0d ch1=%0d want 8/-8", j, o0, o1);
        end
      end
      if (j < 20) drive(1'b1, 2'sd1, -2'sd1); else drive(1'b0, 2'sd0, 2'sd0);
      @(negedge iCLK);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_window();
    test_back_to_back();
    test_backpressure();
    test_rounding();
    test_async_reset();
    test_win_change();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
